// File: rtl/vec_pkg.sv
// Shared definitions for the vector ALU sequencer: op codes, SEW/LMUL encodings,
// sequencer state enum and small SEW helpers.
package vec_pkg;

  localparam logic [5:0] VADD  = 6'd0;
  localparam logic [5:0] VSUB  = 6'd1;
  localparam logic [5:0] VAND  = 6'd2;
  localparam logic [5:0] VOR   = 6'd3;
  localparam logic [5:0] VXOR  = 6'd4;
  localparam logic [5:0] VSLT  = 6'd5;
  localparam logic [5:0] VSLTU = 6'd6;
  localparam logic [5:0] VSLL  = 6'd7;
  localparam logic [5:0] VSRL  = 6'd8;
  localparam logic [5:0] VSRA  = 6'd9;

  localparam logic [10:0] SEW_8   = 11'd8;
  localparam logic [10:0] SEW_16  = 11'd16;
  localparam logic [10:0] SEW_32  = 11'd32;
  localparam logic [10:0] SEW_64  = 11'd64;
  localparam logic [10:0] SEW_128 = 11'd128;

  localparam logic [1:0] LMUL_1 = 2'd0;
  localparam logic [1:0] LMUL_2 = 2'd1;
  localparam logic [1:0] LMUL_4 = 2'd2;
  localparam logic [1:0] LMUL_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_EX,
    ST_WB,
    ST_DONE
  } seq_state_e;

  // log2 of the element size in bytes; only meaningful for legal SEW values
  function automatic logic [2:0] sew_bytes_log2(input logic [10:0] sew);
    case (sew)
      SEW_16:  return 3'd1;
      SEW_32:  return 3'd2;
      SEW_64:  return 3'd3;
      SEW_128: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic sew_legal(input logic [10:0] sew, input int vlen);
    logic enc_ok;
    enc_ok = (sew == SEW_8) || (sew == SEW_16) || (sew == SEW_32) ||
             (sew == SEW_64) || (sew == SEW_128);
    return enc_ok && (int'(sew) <= vlen);
  endfunction

endpackage

// File: rtl/valu_bemask.sv
// Byte write-enable generator: enables the bytes of every element of register
// reg_idx in the group whose flat element index is below vl.
module valu_bemask
  import vec_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VLW  = $clog2(VLEN) + 1
) (
  input  logic [10:0]       sew,
  input  logic [2:0]        reg_idx,
  input  logic [VLW-1:0]    vl,
  output logic [VLEN/8-1:0] be
);

  localparam int NB_LOG2 = $clog2(VLEN / 8);
  localparam int EW      = VLW + 4;

  always_comb begin
    logic [2:0]    sb;
    logic [3:0]    epr_log2;
    logic [EW-1:0] base;
    logic [EW-1:0] e;
    sb       = sew_bytes_log2(sew);
    epr_log2 = 4'(NB_LOG2) - {1'b0, sb};
    base     = EW'(reg_idx) << epr_log2;
    e        = '0;
    be       = '0;
    for (int i = 0; i < VLEN / 8; i++) begin
      e     = base + (EW'(i) >> sb);
      be[i] = (e < EW'(vl));
    end
  end

endmodule

// File: rtl/valu_seq.sv
// Vector ALU sequencer: steps one instruction over an LMUL register group,
// three cycles (read, execute, writeback) per register. Optional macro
// VALU_SEQ_SCALAR_EN adds a scalar operand (i_vx/i_scalar) for operand b.
module valu_seq
  import vec_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VLW  = $clog2(VLEN) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [5:0]        i_ctrl,
  input  logic [10:0]       i_sew,
  input  logic [1:0]        i_lmul,
  input  logic [VLW-1:0]    i_vl,
  input  logic [4:0]        i_vd,
  input  logic [4:0]        i_vs1,
  input  logic [4:0]        i_vs2,
`ifdef VALU_SEQ_SCALAR_EN
  input  logic              i_vx,
  input  logic [63:0]       i_scalar,
`endif
  output logic [4:0]        o_rf_raddr_a,
  output logic [4:0]        o_rf_raddr_b,
  input  logic [VLEN-1:0]   i_rf_rdata_a,
  input  logic [VLEN-1:0]   i_rf_rdata_b,
  output logic              o_rf_we,
  output logic [4:0]        o_rf_waddr,
  output logic [VLEN-1:0]   o_rf_wdata,
  output logic [VLEN/8-1:0] o_rf_wbe,
  output logic [10:0]       o_alu_sew,
  output logic [5:0]        o_alu_ctrl,
  output logic [VLEN-1:0]   o_alu_a,
  output logic [VLEN-1:0]   o_alu_b,
  input  logic [VLEN-1:0]   i_alu_result,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  // Issue handshake: an instruction is taken on a rising edge where i_valid
  // and o_ready are both high; o_ready is high only in IDLE, so i_valid
  // while busy is ignored and nothing is queued.

  seq_state_e          state_q, state_d;
  logic [2:0]          r_q, r_d;
  logic [5:0]          ctrl_q, ctrl_d;
  logic [10:0]         sew_q, sew_d;
  logic [1:0]          lmul_q, lmul_d;
  logic [VLW-1:0]      vl_q, vl_d;
  logic [4:0]          vd_q, vd_d, vs1_q, vs1_d, vs2_q, vs2_d;
  logic [VLEN-1:0]     a_q, a_d, b_q, b_d;
  logic                err_q, err_d;
  logic [2:0]          r_last;
  logic [VLEN/8-1:0]   be;
  logic [VLEN-1:0]     b_src;

`ifdef VALU_SEQ_SCALAR_EN
  logic                vx_q, vx_d;
  logic [63:0]         scalar_q, scalar_d;

  // Replicates the low SEW bits of the scalar into every element slot
  function automatic logic [VLEN-1:0] splat(input logic [63:0] s, input logic [2:0] sb);
    logic [VLEN-1:0] v;
    int              j;
    v = '0;
    for (int i = 0; i < VLEN / 8; i++) begin
      j = i & ((1 << sb) - 1);
      v[i*8 +: 8] = (j < 8) ? s[j*8 +: 8] : 8'h00;
    end
    return v;
  endfunction

  assign b_src = vx_q ? splat(scalar_q, sew_bytes_log2(sew_q)) : i_rf_rdata_b;
`else
  assign b_src = i_rf_rdata_b;
`endif

  assign r_last = 3'((4'd1 << lmul_q) - 4'd1);

  valu_bemask #(.VLEN(VLEN), .VLW(VLW)) u_bemask (
    .sew     (sew_q),
    .reg_idx (r_q),
    .vl      (vl_q),
    .be      (be)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      ctrl_q  <= '0;
      sew_q   <= '0;
      lmul_q  <= '0;
      vl_q    <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      err_q   <= 1'b0;
`ifdef VALU_SEQ_SCALAR_EN
      vx_q     <= 1'b0;
      scalar_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      ctrl_q  <= ctrl_d;
      sew_q   <= sew_d;
      lmul_q  <= lmul_d;
      vl_q    <= vl_d;
      vd_q    <= vd_d;
      vs1_q   <= vs1_d;
      vs2_q   <= vs2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
`ifdef VALU_SEQ_SCALAR_EN
      vx_q     <= vx_d;
      scalar_q <= scalar_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    ctrl_d  = ctrl_q;
    sew_d   = sew_q;
    lmul_d  = lmul_q;
    vl_d    = vl_q;
    vd_d    = vd_q;
    vs1_d   = vs1_q;
    vs2_d   = vs2_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
`ifdef VALU_SEQ_SCALAR_EN
    vx_d     = vx_q;
    scalar_d = scalar_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          ctrl_d = i_ctrl;
          sew_d  = i_sew;
          lmul_d = i_lmul;
          vl_d   = i_vl;
          vd_d   = i_vd;
          vs1_d  = i_vs1;
          vs2_d  = i_vs2;
          r_d    = '0;
          err_d  = !sew_legal(i_sew, VLEN);
`ifdef VALU_SEQ_SCALAR_EN
          vx_d     = i_vx;
          scalar_d = i_scalar;
`endif
          // Illegal SEW or an empty vector finishes without touching the RF
          if (!sew_legal(i_sew, VLEN) || (i_vl == '0)) state_d = ST_DONE;
          else                                         state_d = ST_RD;
        end
      end
      ST_RD: state_d = ST_EX;
      ST_EX: begin
        a_d     = i_rf_rdata_a;
        b_d     = b_src;
        state_d = ST_WB;
      end
      ST_WB: begin
        if (r_q == r_last) begin
          state_d = ST_IDLE;
        end else begin
          r_d     = r_q + 3'd1;
          state_d = ST_RD;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready      = (state_q == ST_IDLE);
    o_busy       = (state_q != ST_IDLE);
    o_alu_sew    = (state_q != ST_IDLE) ? sew_q : '0;
    o_alu_ctrl   = (state_q != ST_IDLE) ? ctrl_q : '0;
    o_rf_raddr_a = '0;
    o_rf_raddr_b = '0;
    o_rf_we      = 1'b0;
    o_rf_waddr   = '0;
    o_rf_wdata   = '0;
    o_rf_wbe     = '0;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (state_q)
      ST_RD: begin
        o_rf_raddr_a = vs2_q + {2'b00, r_q};
        o_rf_raddr_b = vs1_q + {2'b00, r_q};
      end
      ST_WB: begin
        o_rf_we    = 1'b1;
        o_rf_waddr = vd_q + {2'b00, r_q};
        o_rf_wdata = i_alu_result;
        o_rf_wbe   = be;
        o_done     = (r_q == r_last);
      end
      ST_DONE: begin
        o_done = 1'b1;
        o_err  = err_q;
      end
      default: ;
    endcase
  end

  assign o_alu_a = a_q;
  assign o_alu_b = b_q;

endmodule

// File: tb/tb_valu_seq.sv
// Directed bench for valu_seq: registered-read RF model, behavioural ALU,
// expected-write scoreboard and cycle-exact done/err checks.
module tb_valu_seq;
  import vec_pkg::*;

  localparam int VLEN = 128;
  localparam int VLW  = $clog2(VLEN) + 1;
  localparam int NB   = VLEN / 8;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_valid;
  logic              o_ready;
  logic [5:0]        i_ctrl;
  logic [10:0]       i_sew;
  logic [1:0]        i_lmul;
  logic [VLW-1:0]    i_vl;
  logic [4:0]        i_vd, i_vs1, i_vs2;
`ifdef VALU_SEQ_SCALAR_EN
  logic              i_vx;
  logic [63:0]       i_scalar;
`endif
  logic [4:0]        o_rf_raddr_a, o_rf_raddr_b;
  logic [VLEN-1:0]   i_rf_rdata_a, i_rf_rdata_b;
  logic              o_rf_we;
  logic [4:0]        o_rf_waddr;
  logic [VLEN-1:0]   o_rf_wdata;
  logic [NB-1:0]     o_rf_wbe;
  logic [10:0]       o_alu_sew;
  logic [5:0]        o_alu_ctrl;
  logic [VLEN-1:0]   o_alu_a, o_alu_b;
  logic [VLEN-1:0]   i_alu_result;
  logic              o_busy, o_done, o_err;

  logic [VLEN-1:0]   rf [32];
  logic [4:0]        exp_addr_q[$];
  logic [VLEN-1:0]   exp_q[$];
  logic [NB-1:0]     exp_be_q[$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  valu_seq #(.VLEN(VLEN), .VLW(VLW)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_ctrl       (i_ctrl),
    .i_sew        (i_sew),
    .i_lmul       (i_lmul),
    .i_vl         (i_vl),
    .i_vd         (i_vd),
    .i_vs1        (i_vs1),
    .i_vs2        (i_vs2),
`ifdef VALU_SEQ_SCALAR_EN
    .i_vx         (i_vx),
    .i_scalar     (i_scalar),
`endif
    .o_rf_raddr_a (o_rf_raddr_a),
    .o_rf_raddr_b (o_rf_raddr_b),
    .i_rf_rdata_a (i_rf_rdata_a),
    .i_rf_rdata_b (i_rf_rdata_b),
    .o_rf_we      (o_rf_we),
    .o_rf_waddr   (o_rf_waddr),
    .o_rf_wdata   (o_rf_wdata),
    .o_rf_wbe     (o_rf_wbe),
    .o_alu_sew    (o_alu_sew),
    .o_alu_ctrl   (o_alu_ctrl),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .i_alu_result (i_alu_result),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  // Register file with one-cycle read latency
  always @(posedge clk) begin
    i_rf_rdata_a <= rf[o_rf_raddr_a];
    i_rf_rdata_b <= rf[o_rf_raddr_b];
  end

  function automatic logic [VLEN-1:0] alu_f(input logic [5:0] c, input logic [10:0] sew,
                                            input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    logic [VLEN-1:0] m, ea, eb, er, res;
    int              w;
    res = '0;
    if (sew inside {11'd8, 11'd16, 11'd32, 11'd64, 11'd128}) begin
      w = int'(sew);
      m = (w == VLEN) ? '1 : ((VLEN'(1) << w) - VLEN'(1));
      for (int e = 0; e < VLEN / w; e++) begin
        ea = (a >> (e * w)) & m;
        eb = (b >> (e * w)) & m;
        case (c)
          VADD:    er = ea + eb;
          VSUB:    er = ea - eb;
          VAND:    er = ea & eb;
          VSLL:    er = ea << (eb & VLEN'(w - 1));
          default: er = '0;
        endcase
        res = res | ((er & m) << (e * w));
      end
    end
    return res;
  endfunction

  assign i_alu_result = alu_f(o_alu_ctrl, o_alu_sew, o_alu_a, o_alu_b);

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] addr, input logic [VLEN-1:0] data, input logic [NB-1:0] be);
    exp_addr_q.push_back(addr);
    exp_q.push_back(data);
    exp_be_q.push_back(be);
  endtask

  // Issues one instruction and follows it to completion (or to a planted reset
  // on write number rst_at_wr); cycle 1 is the first cycle after acceptance.
  task automatic run_op(input logic [5:0] ctrl, input logic [10:0] sew, input logic [1:0] lmul,
                        input logic [VLW-1:0] vl, input logic [4:0] vd, input logic [4:0] vs1,
                        input logic [4:0] vs2, input int exp_done, input logic exp_err,
                        input int rst_at_wr);
    int done_at;
    int nwr;
    int late;
    bit rst_hit;
    done_at = -1;
    nwr     = 0;
    late    = 0;
    rst_hit = 1'b0;
    @(negedge clk);
    check("ready_idle", o_ready, 1);
    i_ctrl  = ctrl;
    i_sew   = sew;
    i_lmul  = lmul;
    i_vl    = vl;
    i_vd    = vd;
    i_vs1   = vs1;
    i_vs2   = vs2;
    i_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (c == 1 && exp_done > 1) begin
        check("busy", o_busy, 1);
        check("ready_busy", o_ready, 0);
        check("alu_sew", o_alu_sew, sew);
        check("alu_ctrl", o_alu_ctrl, ctrl);
        check("raddr_a", o_rf_raddr_a, vs2);
        check("raddr_b", o_rf_raddr_b, vs1);
      end
      if (o_rf_we) begin
        nwr++;
        if (exp_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          check("waddr", o_rf_waddr, exp_addr_q.pop_front());
          check("wdata", o_rf_wdata, exp_q.pop_front());
          check("wbe", o_rf_wbe, exp_be_q.pop_front());
        end
        if (nwr == rst_at_wr) begin
          i_rst = 1'b1;
          #1;
          check("we_drop", o_rf_we, 0);
          check("busy_rst", o_busy, 0);
          rst_hit = 1'b1;
          break;
        end
      end
      if (o_done) begin
        check("done_cyc", c, exp_done);
        check("err", o_err, exp_err);
        done_at = c;
      end else if (o_err) begin
        check("err_no_done", 1, 0);
      end
      if (done_at > 0 && c == done_at + 1) begin
        check("ready_after", o_ready, 1);
        check("done_pulse", o_done, 0);
        break;
      end
    end
    if (rst_hit) begin
      exp_addr_q.delete();
      exp_q.delete();
      exp_be_q.delete();
      @(negedge clk);
      i_rst = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (o_rf_we || o_done) late++;
      end
      check("post_rst_quiet", late, 0);
      check("ready_post_rst", o_ready, 1);
    end else if (done_at < 0) begin
      check("done_timeout", 0, 1);
    end
    check("writes_left", exp_q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = {NB{8'(i)}};
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ctrl  = '0;
    i_sew   = '0;
    i_lmul  = '0;
    i_vl    = '0;
    i_vd    = '0;
    i_vs1   = '0;
    i_vs2   = '0;
`ifdef VALU_SEQ_SCALAR_EN
    i_vx     = 1'b0;
    i_scalar = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_we", o_rf_we, 0);
    check("rst_wbe", o_rf_wbe, 0);
    check("rst_waddr", o_rf_waddr, 0);
    check("rst_wdata", o_rf_wdata, 0);
    check("rst_raddr_a", o_rf_raddr_a, 0);
    check("rst_alu_a", o_alu_a, 0);
    check("rst_alu_b", o_alu_b, 0);
    check("rst_alu_sew", o_alu_sew, 0);
    i_rst = 1'b0;

    // VADD sew8 lmul1 vl16: 0x01 + 0x02 into v3
    push_wr(5'd3, {NB{8'h03}}, '1);
    run_op(VADD, 11'd8, 2'd0, 8'd16, 5'd3, 5'd2, 5'd1, 3, 1'b0, -1);

    // VSUB sew32 lmul2 vl5: v6-v4, v7-v5 = 0x02020202; second reg only element 4
    push_wr(5'd8, {4{32'h02020202}}, 16'hFFFF);
    push_wr(5'd9, {4{32'h02020202}}, 16'h000F);
    run_op(VSUB, 11'd32, 2'd1, 8'd5, 5'd8, 5'd4, 5'd6, 6, 1'b0, -1);

    // VAND sew16 vl3: three halfwords -> bytes 0..5
    push_wr(5'd1, {NB{8'h05}}, 16'h003F);
    run_op(VAND, 11'd16, 2'd0, 8'd3, 5'd1, 5'd7, 5'd5, 3, 1'b0, -1);

    // vl=0: done one cycle after accept, no writes
    run_op(VAND, 11'd8, 2'd0, 8'd0, 5'd3, 5'd2, 5'd1, 1, 1'b0, -1);

    // illegal sew encodings, including one wider than VLEN
    run_op(VADD, 11'h00C, 2'd0, 8'd16, 5'd3, 5'd2, 5'd1, 1, 1'b1, -1);
    run_op(VADD, 11'd256, 2'd0, 8'd16, 5'd3, 5'd2, 5'd1, 1, 1'b1, -1);

    // lmul8 vd=28 with vl above capacity: addresses wrap 28..31,0..3
    for (int j = 0; j < 8; j++) push_wr(5'(28 + j), {NB{8'(30 + 2 * j)}}, '1);
    run_op(VADD, 11'd8, 2'd3, 8'd200, 5'd28, 5'd20, 5'd10, 24, 1'b0, -1);

    // same group, reset asserted during the third writeback
    for (int j = 0; j < 8; j++) push_wr(5'(28 + j), {NB{8'(30 + 2 * j)}}, '1);
    run_op(VADD, 11'd8, 2'd3, 8'd200, 5'd28, 5'd20, 5'd10, 24, 1'b0, 3);

`ifdef VALU_SEQ_SCALAR_EN
    rf[31]   = {8{16'h0001}};
    i_vx     = 1'b1;
    i_scalar = 64'd3;
    push_wr(5'd4, {8{16'h0008}}, '1);
    run_op(VSLL, 11'd16, 2'd0, 8'd8, 5'd4, 5'd0, 5'd31, 3, 1'b0, -1);
    i_vx = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/valu_seq.md
Name: valu_seq

Overview:
Sequencer that executes one vector integer instruction over a register group (LMUL = 1/2/4/8) by stepping the combinational vector ALU one VLEN-wide register at a time. It reads operands from the vector register file, drives the ALU's SEW and operation control, and writes results back with byte enables that honour vl (tail-undisturbed). It sits between the vector decode/issue stage and the register file plus ALU, with a valid/ready issue handshake.

Parameters:
VLEN, 128, vector register width in bits (power of two, >= 64)
VLW, $clog2(VLEN)+1, width of the vl input; max vl = 8*VLEN/8 = VLEN

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_valid  in  1  issue request
o_ready  out  1  high in IDLE only
i_ctrl  in  6  ALU op code (VADD/VSUB/VAND/VOR/VXOR/VSLT/VSLTU/VSLL/VSRL/VSRA encodings)
i_sew  in  11  element width in bits: 8/16/32/64/128
i_lmul  in  2  group size: 0=1, 1=2, 2=4, 3=8
i_vl  in  VLW  active element count
i_vd, i_vs1, i_vs2  in  5 each  base register indices
o_rf_raddr_a, o_rf_raddr_b  out  5 each  RF read addresses; RF read data valid one cycle later
i_rf_rdata_a, i_rf_rdata_b  in  VLEN each  RF read data
o_rf_we  out  1  write strobe
o_rf_waddr  out  5  write address
o_rf_wdata  out  VLEN  write data
o_rf_wbe  out  VLEN/8  byte write enables
o_alu_sew  out  11  to ALU
o_alu_ctrl  out  6  to ALU
o_alu_a, o_alu_b  out  VLEN each  ALU operands (a = vs2 slice, b = vs1 slice)
i_alu_result  in  VLEN  ALU result
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle pulse with o_done on illegal sew/lmul

Behaviour:
- Reset values: state IDLE, o_ready=1, o_busy=0, o_done=0, o_err=0, o_rf_we=0, o_rf_wbe=0; all address/data/operand outputs 0.
- Issue: accept when i_valid && o_ready; latch ctrl, sew, lmul, vl, vd, vs1, vs2; clear reg index r=0.
- States: IDLE -> RD (drive raddr_a=vs2+r, raddr_b=vs1+r) -> EX (capture rdata into operand registers; ALU evaluates) -> WB (o_rf_we=1, waddr=vd+r, wdata=i_alu_result, wbe per mask) -> RD with r+1 if r+1 < 2^lmul, else IDLE.
- o_done (and o_err if applicable) pulses in the cycle of the final WB; o_ready rises the following cycle. Per-register cost 3 cycles; LMUL=1 done at 3rd cycle after accept, LMUL=8 at 24th.
- o_alu_sew/o_alu_ctrl held at latched values from accept until return to IDLE.
- Byte mask: element index e = r*(VLEN/SEW)+k; bytes of element k enabled iff e < vl. Disabled bytes not written (tail undisturbed).
- vl=0: go straight to a single DONE cycle after accept; no writes, o_done pulses 1 cycle after accept.
- vl > VLEN/SEW*2^lmul: clamped to group capacity (all bytes enabled).
- Illegal sew (not 8/16/32/64/128, or > VLEN): no RF writes, o_done+o_err pulse 1 cycle after accept.
- Register index arithmetic is 5-bit, wraps modulo 32.
- i_valid while busy ignored (o_ready=0); no queuing.
- Reset mid-operation: immediate return to IDLE, o_rf_we drops asynchronously, remaining group registers not written, no o_done.

Optional Feature:
VALU_SEQ_SCALAR_EN: adds ports i_vx (1) and i_scalar (64); when i_vx latched high, o_alu_b is the low SEW bits of i_scalar (latched at accept) replicated across all elements and raddr_b is don't-care. Without the macro, ports are absent and operand b always comes from vs1.

Decomposition:
- Shared package vec_pkg: ALU op-code constants, SEW encodings, LMUL encoding, sequencer state enum.
- One sub-module: valu_bemask (combinational; inputs sew, reg index, vl; output VLEN/8 byte enables).

Test Plan:
- VADD sew=8 lmul=0 vl=16, vs2=v1 all 0x01, vs1=v2 all 0x02, vd=v3 -> one write to v3, wdata all 0x03, wbe all 1, o_done at cycle 3.
- VSUB sew=32 lmul=1 vl=5 -> writes v(vd) wbe 0xFFFF then v(vd+1) wbe 0x000F; o_done at cycle 6.
- vl=0 VAND -> no o_rf_we, o_done 1 cycle after accept, o_ready next cycle.
- sew=11'h0C -> o_done and o_err same cycle 1 cycle after accept, no write.
- lmul=3 vd=28 -> write addresses 28..31,0..3 in order; assert i_rst during 3rd WB -> no further writes, no o_done, o_ready=1 after reset.
- With VALU_SEQ_SCALAR_EN: VSLL sew=16 i_vx=1 i_scalar=3, vs2 all 0x0001 -> wdata all 0x0008.
